// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data access,
// with per-stage stalls and an ack timeout. Build option ARB_RR_EN: round-robin on conflicts.
module unified_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_done,
  output logic [DW-1:0] i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_done,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata
);

  // state  | meaning
  // IDLE   | no memory transaction; arbitrate between eligible requesters
  // BUSY_I | fetch transaction outstanding on the memory port
  // BUSY_D | data transaction outstanding on the memory port
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] wait_cnt;
  logic       i_elig;
  logic       d_elig;
  logic       grant_i;
  logic       grant_d;
  logic       ack_ok;
  logic       time_up;

  // A port whose done pulse is showing this cycle may still hold req; it is not re-granted.
  assign i_elig = i_req & ~i_done;
  assign d_elig = d_req & ~d_done;

`ifdef ARB_RR_EN
  logic last_grant_d;

  assign grant_d = d_elig & (~i_elig | ~last_grant_d);

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant_d <= 1'b0;
    end else if (state == IDLE && (grant_i || grant_d)) begin
      last_grant_d <= grant_d;
    end
  end
`else
  assign grant_d = d_elig;
`endif

  assign grant_i   = i_elig & ~grant_d;
  assign stall_if  = i_req & ~i_done;
  assign stall_mem = d_req & ~d_done;

  // The first cycle with m_req high (wait_cnt == 0) never accepts an ack.
  assign ack_ok  = m_ack & (wait_cnt != 8'd0);
  assign time_up = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      i_done   <= 1'b0;
      i_err    <= 1'b0;
      i_rdata  <= '0;
      d_done   <= 1'b0;
      d_err    <= 1'b0;
      d_rdata  <= '0;
      m_req    <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else begin
      i_done <= 1'b0;
      i_err  <= 1'b0;
      d_done <= 1'b0;
      d_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state    <= BUSY_D;
            m_req    <= 1'b1;
            m_we     <= d_we;
            m_addr   <= d_addr;
            m_wdata  <= d_wdata;
            wait_cnt <= 8'd0;
          end else if (grant_i) begin
            state    <= BUSY_I;
            m_req    <= 1'b1;
            m_we     <= 1'b0;
            m_addr   <= i_addr;
            m_wdata  <= '0;
            wait_cnt <= 8'd0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (ack_ok || time_up) begin
            state <= IDLE;
            m_req <= 1'b0;
            m_we  <= 1'b0;
            if (state == BUSY_I) begin
              i_done  <= 1'b1;
              i_err   <= ~ack_ok;
              i_rdata <= ack_ok ? m_rdata : '0;
            end else begin
              d_done <= 1'b1;
              d_err  <= ~ack_ok;
              // Stores never touch the load-data register.
              if (!m_we) begin
                d_rdata <= ack_ok ? m_rdata : '0;
              end
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: expected completions are queued at issue time from a
// memory reference model; a monitor pops and compares on every done pulse.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_done, i_err, d_done, d_err;
  logic [31:0] i_rdata, d_rdata;
  logic        stall_if, stall_mem;
  logic        m_req, m_we, m_ack;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .stall_if(stall_if), .stall_mem(stall_mem),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model state
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last_d_rdata = 32'h0;
  logic [32:0] i_exp_q [$];
  logic [32:0] d_exp_q [$];
  logic        i_out_valid = 1'b0, d_out_valid = 1'b0, d_out_we = 1'b0;
  logic [31:0] i_out_addr = 32'h0, d_out_addr = 32'h0, d_out_wdata = 32'h0;

  // memory environment state
  logic [31:0] mem_arr [logic [31:0]];
  int          force_lat = 0;

  // monitor observations
  logic        prev_mreq = 1'b0;
  int          rise_cyc = 0;
  int          mreq_len = 0;
  logic        rise_we = 1'b0;
  logic [31:0] rise_wdata = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return default_word(a);
  endfunction

  function automatic logic is_dead(input logic [31:0] a);
    return a[31:28] == 4'hF;
  endfunction

  // Memory: acks after 1..3 cycles; the dead region acks only once, after the timeout has fired.
  initial begin : memory
    logic [31:0] ma, mwd;
    logic        mwe;
    int          lat;
    m_ack = 1'b0;
    m_rdata = 32'h0;
    @(negedge clk);
    forever begin
      while (!m_req) @(negedge clk);
      ma = m_addr; mwe = m_we; mwd = m_wdata;
      if (is_dead(ma)) lat = 4;
      else if (force_lat != 0) lat = force_lat;
      else lat = int'($urandom_range(1, 3));
      repeat (lat) @(negedge clk);
      m_ack = 1'b1;
      if (mwe) m_rdata = $urandom;
      else m_rdata = mem_arr.exists(ma) ? mem_arr[ma] : default_word(ma);
      if (mwe && !is_dead(ma)) mem_arr[ma] = mwd;
      @(negedge clk);
      m_ack = 1'b0;
      m_rdata = $urandom;
    end
  end

  initial begin : monitor
    logic [32:0] e;
    logic        ok;
    forever begin
      @(negedge clk);
      if (i_done || d_done) chk("done_exclusive", 32'(i_done & d_done), 32'h0);
      if (i_done) begin
        if (i_exp_q.size() == 0) chk("i_done_unexpected", 32'h1, 32'h0);
        else begin
          e = i_exp_q.pop_front();
          chk("i_rdata", i_rdata, e[31:0]);
          chk("i_err", 32'(i_err), 32'(e[32]));
        end
      end
      if (d_done) begin
        if (d_exp_q.size() == 0) chk("d_done_unexpected", 32'h1, 32'h0);
        else begin
          e = d_exp_q.pop_front();
          chk("d_rdata", d_rdata, e[31:0]);
          chk("d_err", 32'(d_err), 32'(e[32]));
        end
      end
      if (m_req && !prev_mreq) begin
        rise_cyc = cyc; rise_we = m_we; rise_wdata = m_wdata;
        ok = (d_out_valid && m_addr == d_out_addr && m_we == d_out_we &&
              (!d_out_we || m_wdata == d_out_wdata)) ||
             (i_out_valid && m_addr == i_out_addr && !m_we);
        chk("mreq_matches_pending", 32'(ok), 32'h1);
      end
      if (!m_req && prev_mreq) mreq_len = cyc - rise_cyc;
      prev_mreq = m_req;
    end
  end

  task automatic run_fetch(input logic [31:0] a, input bit keep, output int lat);
    int n, t0, stalls;
    i_exp_q.push_back(is_dead(a) ? {1'b1, 32'h0} : {1'b0, ref_read(a)});
    i_out_valid = 1'b1; i_out_addr = a;
    i_req = 1'b1; i_addr = a;
    t0 = cyc; n = 0; stalls = 0;
    @(negedge clk);
    while (!i_done && n < 40) begin
      if (stall_if) stalls++;
      n++;
      @(negedge clk);
    end
    lat = cyc - t0;
    if (!i_done) chk("i_done_timeout", 32'h0, 32'h1);
    else begin
      chk("stall_if_while_waiting", 32'(stalls), 32'(lat - 1));
      chk("stall_if_on_done", 32'(stall_if), 32'h0);
    end
    i_out_valid = 1'b0;
    if (!keep) i_req = 1'b0;
  endtask

  task automatic run_data(input logic [31:0] a, input logic we, input logic [31:0] wd, output int lat);
    int n, t0, stalls;
    if (is_dead(a)) begin
      if (!we) last_d_rdata = 32'h0;
      d_exp_q.push_back({1'b1, last_d_rdata});
    end else begin
      if (we) ref_mem[a] = wd;
      else last_d_rdata = ref_read(a);
      d_exp_q.push_back({1'b0, last_d_rdata});
    end
    d_out_valid = 1'b1; d_out_addr = a; d_out_we = we; d_out_wdata = wd;
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    t0 = cyc; n = 0; stalls = 0;
    @(negedge clk);
    while (!d_done && n < 40) begin
      if (stall_mem) stalls++;
      n++;
      @(negedge clk);
    end
    lat = cyc - t0;
    if (!d_done) chk("d_done_timeout", 32'h0, 32'h1);
    else begin
      chk("stall_mem_while_waiting", 32'(stalls), 32'(lat - 1));
      chk("stall_mem_on_done", 32'(stall_mem), 32'h0);
    end
    d_out_valid = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_flags"}, 32'({i_done, i_err, d_done, d_err, stall_if, stall_mem, m_req, m_we}), 32'h0);
    chk({tag, "_rdata"}, i_rdata | d_rdata, 32'h0);
    chk({tag, "_mbus"}, m_addr | m_wdata, 32'h0);
  endtask

  initial begin : watchdog
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int li, ld, l1, l2, l3, t0;
    rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    ref_mem[32'h100] = 32'h00500093;
    mem_arr[32'h100] = 32'h00500093;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // fetch only, ack latency 2
    force_lat = 2;
    t0 = cyc;
    fork
      run_fetch(32'h100, 1'b0, li);
      begin #1 chk("t1_stall_if_cycle0", 32'(stall_if), 32'h1); end
    join
    chk("t1_done_latency", 32'(li), 32'd4);
    chk("t1_mreq_rise_cycle", 32'(rise_cyc - t0), 32'd1);
    repeat (2) @(negedge clk);

    // simultaneous requests, ack latency 1
    force_lat = 1;
    fork
      run_fetch(32'h104, 1'b0, li);
      run_data(32'h200, 1'b0, 32'h0, ld);
    join
    chk("t2_first_d_lat", 32'(ld), 32'd3);
    chk("t2_first_i_lat", 32'(li), 32'd6);
    repeat (2) @(negedge clk);
    run_data(32'h204, 1'b1, 32'h1234_5678, ld);
    repeat (2) @(negedge clk);
    fork
      run_fetch(32'h108, 1'b0, li);
      run_data(32'h208, 1'b0, 32'h0, ld);
    join
`ifdef ARB_RR_EN
    chk("t2_second_i_lat", 32'(li), 32'd3);
    chk("t2_second_d_lat", 32'(ld), 32'd6);
`else
    chk("t2_second_d_lat", 32'(ld), 32'd3);
    chk("t2_second_i_lat", 32'(li), 32'd6);
`endif
    repeat (2) @(negedge clk);

    // store
    run_data(32'h40, 1'b1, 32'hDEADBEEF, ld);
    chk("t3_store_lat", 32'(ld), 32'd3);
    chk("t3_m_we", 32'(rise_we), 32'h1);
    chk("t3_m_wdata", rise_wdata, 32'hDEADBEEF);
    repeat (2) @(negedge clk);

    // timeout on a load, late ack afterwards
    run_data(32'hF000_0010, 1'b0, 32'h0, ld);
    chk("t4_abort_lat", 32'(ld), 32'd5);
    repeat (4) @(negedge clk);
    chk("t4_mreq_high_cycles", 32'(mreq_len), 32'd4);

    // reset in the middle of a fetch
    force_lat = 3;
    i_out_valid = 1'b1; i_out_addr = 32'h300;
    i_req = 1'b1; i_addr = 32'h300;
    repeat (2) @(negedge clk);
    chk("t5_busy_before_reset", 32'(m_req), 32'h1);
    rst = 1'b0; i_req = 1'b0; i_out_valid = 1'b0;
    last_d_rdata = 32'h0;
    @(negedge clk);
    check_all_zero("t5_after_reset");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    force_lat = 0;
    run_fetch(32'h308, 1'b0, li);
    chk("t5_post_reset_lat_in_range", 32'(li >= 3 && li <= 5), 32'h1);
    repeat (2) @(negedge clk);

    // back-to-back fetches with req held
    force_lat = 1;
    run_fetch(32'h0, 1'b1, l1);
    run_fetch(32'h4, 1'b1, l2);
    run_fetch(32'h8, 1'b0, l3);
    chk("t6_lat_first", 32'(l1), 32'd3);
    chk("t6_lat_second", 32'(l2), 32'd4);
    chk("t6_lat_third", 32'(l3), 32'd4);
    repeat (2) @(negedge clk);

    // randomized traffic on both ports
    force_lat = 0;
    fork
      begin
        int lat;
        bit keep;
        logic [31:0] a;
        for (int k = 0; k < 40; k++) begin
          if ($urandom_range(0, 7) == 0) a = 32'hF000_1000 + 32'($urandom_range(0, 15) << 2);
          else a = 32'($urandom_range(0, 1023) << 2);
          keep = (k != 39) && ($urandom_range(0, 1) == 1);
          run_fetch(a, keep, lat);
          if (!keep) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
      begin
        int lat;
        logic [31:0] a;
        for (int k = 0; k < 40; k++) begin
          if ($urandom_range(0, 7) == 0) a = 32'hF000_0000 + 32'($urandom_range(0, 15) << 2);
          else a = 32'h1000_0000 + 32'($urandom_range(0, 15) << 2);
          run_data(a, 1'($urandom_range(0, 1)), $urandom, lat);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    join
    repeat (8) @(negedge clk);
    chk("i_queue_drained", 32'(i_exp_q.size()), 32'h0);
    chk("d_queue_drained", 32'(d_exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the instruction-fetch requester (IF stage, read-only) and the data requester (MEM stage, load/store).
- Sits between the pipeline stages and the memory.
- Serialises accesses, runs the memory handshake and generates per-stage stall signals so the pipeline registers can hold.
- Aborts a transaction with an error if the memory fails to acknowledge within a bounded time.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- TIMEOUT, 16: maximum cycles waiting for m_ack before abort; legal range 2..255.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- i_req  in  1  fetch request; held until i_done.
- i_addr  in  AW  fetch address; stable while i_req.
- i_done  out  1  one-cycle pulse: fetch complete.
- i_rdata  out  DW  fetched word; valid when i_done.
- i_err  out  1  with i_done: fetch timed out.
- d_req  in  1  data request; held until d_done.
- d_we  in  1  1 = store, 0 = load; stable while d_req.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_done  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DW  load data; valid when d_done.
- d_err  out  1  with d_done: data access timed out.
- stall_if  out  1  i_req & ~i_done.
- stall_mem  out  1  d_req & ~d_done.
- m_req  out  1  memory request; held until m_ack or abort.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_ack  in  1  memory completion pulse; read data valid this cycle.
- m_rdata  in  DW  memory read data.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D.
- Reset (rst=0 at a clock edge):
  - State goes to IDLE and the wait counter clears.
  - All outputs go to 0, including i_rdata and d_rdata.
  - Any in-flight transaction is dropped and no done pulse is issued.
  - m_req is low from the first cycle after reset.
- IDLE, eligible requesters:
  - A requester is eligible when its req=1 and its own done is not asserted this cycle. This prevents re-granting a requester that is dropping req in its done cycle.
  - Only d eligible: go to BUSY_D. Only i eligible: go to BUSY_I.
  - Both eligible: d wins (fixed priority); the in-order older instruction goes first.
- On entering BUSY_x:
  - m_req, m_we, m_addr and m_wdata are registered from requester x.
  - m_we is 0 for fetches.
  - Wait counter loads 0.
- BUSY_x, m_ack=1:
  - m_req drops next cycle and state goes to IDLE.
  - Next cycle x_done=1 for exactly 1 cycle with x_err=0.
  - For reads, x_rdata = m_rdata captured on the ack cycle.
  - x_rdata holds its value until the next done for that port.
- BUSY_x, m_ack=0:
  - Counter increments.
  - When the counter reaches TIMEOUT-1 without ack: abort, drop m_req, state goes to IDLE.
  - Next cycle x_done=1, x_err=1 and x_rdata=0.
- An m_ack arriving while in IDLE (late ack after abort) is ignored.
- m_ack is never sampled in the cycle m_req first rises. Minimum latency is req→ack 1 cycle, then done 1 cycle after ack. Total from req to done is at least 3 cycles when idle.
- Stores report done like loads; d_rdata is not updated on stores.
- The arbiter never issues two memory requests concurrently; m_req is low for at least 1 cycle between transactions.
- i_done and d_done are never asserted in the same cycle.
- Requester dropping req before done is illegal; behaviour is undefined but must not hang, because the timeout still completes.

Optional Feature:
- ARB_RR_EN defined:
  - Round-robin on conflict. A last_grant flop (reset to i) records the most recent grant.
  - When both are eligible, grant the port not granted last.
- ARB_RR_EN undefined: fixed data-over-fetch priority as above; no last_grant flop.

Test Plan:
1. Fetch only, ack latency 2:
   - Stimulus: i_req=1, i_addr=0x100, m_rdata=0x00500093.
   - Required response: m_req rises cycle 1 with m_addr=0x100 and m_we=0. m_ack at cycle 3. i_done pulse at cycle 4 with i_rdata=0x00500093, i_err=0. stall_if high cycles 0-3.
2. Simultaneous requests:
   - Stimulus: i_req (0x104) and d_req load (0x200) in the same cycle, ack latency 1.
   - Required response: data served first, d_done then i_done, separated by at least 3 cycles; with ARB_RR_EN, after reset (last_grant=i) data still wins first, and on a second conflict fetch wins.
3. Store:
   - Stimulus: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF.
   - Required response: m_we=1, m_wdata=0xDEADBEEF. d_done pulses one cycle after ack. d_rdata unchanged.
4. Timeout:
   - Stimulus: TIMEOUT=4, memory never acks on a d load.
   - Required response: m_req drops after 4 BUSY cycles. d_done=1, d_err=1, d_rdata=0. A late m_ack in IDLE causes no done.
5. Reset mid-transaction:
   - Stimulus: rst=0 while in BUSY_I before ack.
   - Required response: next cycle m_req=0, no i_done, all outputs 0. After release, a new request completes normally.
6. Back-to-back fetches:
   - Stimulus: i_req held continuously, addresses 0x0, 0x4, 0x8, ack latency 1.
   - Required response: three i_done pulses with correct data. No duplicate grant in any done cycle.
